// File: rtl/lsu_mem_port.sv
// Single-client load/store port: alignment/funct3 checking, registered memory read,
// read-modify-write for sub-word stores, and tagged, sign/zero-extended responses.
module lsu_mem_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_fault,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  typedef enum logic [2:0] {
    IDLE,
    FAULT,
    LD_REQ,
    LD_WAIT,
    RMW_REQ,
    RMW_WAIT,
    ST_WRITE
  } state_t;

  state_t                r_state, w_state_n;
  logic [2:0]            r_funct3, w_funct3_n;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_n;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_n;
  logic [TAG_WIDTH-1:0]  r_tag, w_tag_n;
  logic                  r_drop, w_drop_n;

  logic                  r_resp_valid, w_resp_valid_n;
  logic [TAG_WIDTH-1:0]  r_resp_tag, w_resp_tag_n;
  logic [DATA_WIDTH-1:0] r_resp_data, w_resp_data_n;
  logic                  r_resp_fault, w_resp_fault_n;
  logic                  r_mem_rd_en, w_mem_rd_en_n;
  logic [ADDR_WIDTH-1:0] r_mem_raddr, w_mem_raddr_n;
  logic                  r_mem_write_en, w_mem_write_en_n;
  logic [ADDR_WIDTH-1:0] r_mem_waddr, w_mem_waddr_n;
  logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_n;

  logic                  w_illegal;
  logic                  w_misalign;
  logic [DATA_WIDTH-1:0] w_ld_ext;
  logic [DATA_WIDTH-1:0] w_merge;

  // Request legality, evaluated on the raw request so the fault path needs no extra state.
  always_comb begin
    if (req_is_store) begin
      w_illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    end else begin
      w_illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
    end
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Memory returns the window starting at the request address, so the low bits are the operand.
  always_comb begin
    case (r_funct3)
      3'b000:  w_ld_ext = {{(DATA_WIDTH-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'b100:  w_ld_ext = {{(DATA_WIDTH-8){1'b0}}, mem_rdata[7:0]};
      3'b001:  w_ld_ext = {{(DATA_WIDTH-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'b101:  w_ld_ext = {{(DATA_WIDTH-16){1'b0}}, mem_rdata[15:0]};
      default: w_ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    if (r_funct3[0]) begin
      w_merge = {mem_rdata[DATA_WIDTH-1:16], r_wdata[15:0]};
    end else begin
      w_merge = {mem_rdata[DATA_WIDTH-1:8], r_wdata[7:0]};
    end
  end

  always_comb begin
    w_state_n        = r_state;
    w_funct3_n       = r_funct3;
    w_addr_n         = r_addr;
    w_wdata_n        = r_wdata;
    w_tag_n          = r_tag;
    w_drop_n         = r_drop;
    w_resp_valid_n   = 1'b0;
    w_resp_tag_n     = r_resp_tag;
    w_resp_data_n    = r_resp_data;
    w_resp_fault_n   = r_resp_fault;
    w_mem_rd_en_n    = 1'b0;
    w_mem_raddr_n    = r_mem_raddr;
    w_mem_write_en_n = 1'b0;
    w_mem_waddr_n    = r_mem_waddr;
    w_mem_wdata_n    = r_mem_wdata;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_funct3_n = req_funct3;
          w_addr_n   = req_addr;
          w_wdata_n  = req_wdata;
          w_tag_n    = req_tag;
          w_drop_n   = 1'b0;
          if (w_illegal || w_misalign) begin
            w_state_n = FAULT;
          end else if (!req_is_store) begin
            w_drop_n  = flush;
            w_state_n = LD_REQ;
          end else if (req_funct3 == 3'b010) begin
            w_state_n = ST_WRITE;
          end else begin
            w_state_n = RMW_REQ;
          end
        end
      end
      FAULT: begin
        w_resp_valid_n = 1'b1;
        w_resp_tag_n   = r_tag;
        w_resp_data_n  = '0;
        w_resp_fault_n = 1'b1;
        w_state_n      = IDLE;
      end
      LD_REQ: begin
        w_mem_rd_en_n = 1'b1;
        w_mem_raddr_n = r_addr;
        if (flush) w_drop_n = 1'b1;
        w_state_n = LD_WAIT;
      end
      LD_WAIT: begin
        if (flush) w_drop_n = 1'b1;
        if (mem_rdata_valid) begin
          if (!r_drop && !flush) begin
            w_resp_valid_n = 1'b1;
            w_resp_tag_n   = r_tag;
            w_resp_data_n  = w_ld_ext;
            w_resp_fault_n = 1'b0;
          end
          w_drop_n  = 1'b0;
          w_state_n = IDLE;
        end
      end
      RMW_REQ: begin
        w_mem_rd_en_n = 1'b1;
        w_mem_raddr_n = r_addr;
        w_state_n     = RMW_WAIT;
      end
      RMW_WAIT: begin
        if (mem_rdata_valid) begin
          // Strobe is launched here so the merged write lands as ST_WRITE is entered.
          w_wdata_n        = w_merge;
          w_mem_write_en_n = 1'b1;
          w_mem_waddr_n    = r_addr;
          w_mem_wdata_n    = w_merge;
          w_state_n        = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // First visit launches the strobe; the response follows the cycle the write is issued.
        if (!r_mem_write_en) begin
          w_mem_write_en_n = 1'b1;
          w_mem_waddr_n    = r_addr;
          w_mem_wdata_n    = r_wdata;
        end else begin
          w_resp_valid_n = 1'b1;
          w_resp_tag_n   = r_tag;
          w_resp_data_n  = '0;
          w_resp_fault_n = 1'b0;
          w_state_n      = IDLE;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_funct3       <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_tag          <= '0;
      r_drop         <= 1'b0;
      r_resp_valid   <= 1'b0;
      r_resp_tag     <= '0;
      r_resp_data    <= '0;
      r_resp_fault   <= 1'b0;
      r_mem_rd_en    <= 1'b0;
      r_mem_raddr    <= '0;
      r_mem_write_en <= 1'b0;
      r_mem_waddr    <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_state        <= w_state_n;
      r_funct3       <= w_funct3_n;
      r_addr         <= w_addr_n;
      r_wdata        <= w_wdata_n;
      r_tag          <= w_tag_n;
      r_drop         <= w_drop_n;
      r_resp_valid   <= w_resp_valid_n;
      r_resp_tag     <= w_resp_tag_n;
      r_resp_data    <= w_resp_data_n;
      r_resp_fault   <= w_resp_fault_n;
      r_mem_rd_en    <= w_mem_rd_en_n;
      r_mem_raddr    <= w_mem_raddr_n;
      r_mem_write_en <= w_mem_write_en_n;
      r_mem_waddr    <= w_mem_waddr_n;
      r_mem_wdata    <= w_mem_wdata_n;
    end
  end

  assign req_ready    = (r_state == IDLE);
  assign resp_valid   = r_resp_valid;
  assign resp_tag     = r_resp_tag;
  assign resp_data    = r_resp_data;
  assign resp_fault   = r_resp_fault;
  assign mem_rd_en    = r_mem_rd_en;
  assign mem_raddr    = r_mem_raddr;
  assign mem_write_en = r_mem_write_en;
  assign mem_waddr    = r_mem_waddr;
  assign mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port against a byte-addressed memory with registered read
// and negedge write.
module tb_lsu_mem_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [5:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic [5:0]  resp_tag;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic        mem_rd_en;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic        mem_write_en;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;

  lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .flush(flush),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data), .resp_fault(resp_fault),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid),
    .mem_write_en(mem_write_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  logic [7:0] m [0:1023];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rdata_valid <= 1'b0;
      mem_rdata       <= '0;
    end else begin
      mem_rdata_valid <= mem_rd_en;
      if (mem_rd_en)
        mem_rdata <= {m[int'(mem_raddr[9:0]) + 3], m[int'(mem_raddr[9:0]) + 2],
                      m[int'(mem_raddr[9:0]) + 1], m[int'(mem_raddr[9:0])]};
    end
  end

  always @(negedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < 4; i++) m[int'(mem_waddr[9:0]) + i] = mem_wdata[8*i +: 8];
    end
  end

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: strobe bookkeeping and response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) rd_cnt++;
      if (mem_write_en) begin
        wr_cnt++;
        last_wa = mem_waddr;
        last_wd = mem_wdata;
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_resp", 32'(resp_tag), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("resp_tag", 32'(resp_tag), 32'(e.tag));
          check("resp_data", resp_data, e.data);
          check("resp_fault", 32'(resp_fault), 32'(e.fault));
          check("resp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic setw(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) m[a + i] = v[8*i +: 8];
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [5:0] tag, input bit push,
                       input logic [31:0] exp_data, input bit exp_fault, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_tag = tag;
    @(posedge clk);
    #1;
    if (push) begin
      e.tag = tag; e.data = exp_data; e.fault = exp_fault; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd0, wr0;
    for (int i = 0; i < 1024; i++) m[i] = 8'(i);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    check("rst_mem_waddr", mem_waddr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Loads with sign/zero extension, issued back to back
    setw(32'h100, 32'h8765_43A1);
    issue(1'b0, 3'b000, 32'h100, 32'h0, 6'd1, 1'b1, 32'hFFFF_FFA1, 1'b0, 3);
    issue(1'b0, 3'b100, 32'h100, 32'h0, 6'd2, 1'b1, 32'h0000_00A1, 1'b0, 3);
    issue(1'b0, 3'b001, 32'h102, 32'h0, 6'd3, 1'b1, 32'hFFFF_8765, 1'b0, 3);
    issue(1'b0, 3'b101, 32'h102, 32'h0, 6'd4, 1'b1, 32'h0000_8765, 1'b0, 3);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 6'd5, 1'b1, 32'h8765_43A1, 1'b0, 3);
    drain();

    // Halfword store via read-modify-write
    setw(32'h100, 32'h1122_3344);
    setw(32'h104, 32'h5566_7788);
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b1, 3'b001, 32'h100, 32'hCAFE_BEEF, 6'd6, 1'b1, 32'h0, 1'b0, 4);
    drain();
    check("sh_reads", 32'(rd_cnt - rd0), 32'd1);
    check("sh_writes", 32'(wr_cnt - wr0), 32'd1);
    check("sh_wdata", last_wd, 32'h1122_BEEF);
    check("sh_waddr", last_wa, 32'h100);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 6'd7, 1'b1, 32'h1122_BEEF, 1'b0, 3);
    drain();

    // Byte store at the top byte of a word, neighbour word untouched
    setw(32'h100, 32'h1122_3344);
    issue(1'b1, 3'b000, 32'h103, 32'h0000_005A, 6'd8, 1'b1, 32'h0, 1'b0, 4);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 6'd9, 1'b1, 32'h5A22_3344, 1'b0, 3);
    issue(1'b0, 3'b010, 32'h104, 32'h0, 6'd10, 1'b1, 32'h5566_7788, 1'b0, 3);
    drain();

    // Word store followed immediately by a load of the same word
    issue(1'b1, 3'b010, 32'h108, 32'hDEAD_BEEF, 6'd11, 1'b1, 32'h0, 1'b0, 2);
    issue(1'b0, 3'b010, 32'h108, 32'h0, 6'd12, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
    drain();

    // Faults: no memory traffic, single-cycle response
    rd0 = rd_cnt; wr0 = wr_cnt;
    issue(1'b0, 3'b010, 32'h102, 32'h0, 6'd13, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b001, 32'h101, 32'hFFFF_FFFF, 6'd14, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b0, 3'b011, 32'h100, 32'h0, 6'd15, 1'b1, 32'h0, 1'b1, 1);
    issue(1'b1, 3'b100, 32'h100, 32'h1234_5678, 6'd16, 1'b1, 32'h0, 1'b1, 1);
    drain();
    check("fault_reads", 32'(rd_cnt - rd0), 32'd0);
    check("fault_writes", 32'(wr_cnt - wr0), 32'd0);

    // Flush during LD_WAIT drops the response
    issue(1'b0, 3'b010, 32'h100, 32'h0, 6'd20, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready_low", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("flush_ready_back", 32'(req_ready), 32'd1);
    issue(1'b0, 3'b001, 32'h104, 32'h0, 6'd21, 1'b1, 32'h0000_7788, 1'b0, 3);
    drain();

    // Reset during RMW_WAIT abandons the store
    setw(32'h100, 32'h1122_3344);
    wr0 = wr_cnt;
    issue(1'b1, 3'b000, 32'h100, 32'h0000_0077, 6'd22, 1'b0, 32'h0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid_rst_raddr", mem_raddr, 32'd0);
    check("mid_rst_write_en", 32'(mem_write_en), 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_writes", 32'(wr_cnt - wr0), 32'd0);
    issue(1'b0, 3'b010, 32'h100, 32'h0, 6'd23, 1'b1, 32'h1122_3344, 1'b0, 3);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
